coeff_bank_server: RTL and testbench
====================================

// Module: coeff_bank_server
// PURPOSE
//  Coefficient memory responder for the 8-channel filter bank (profir).
//  - Serves profir's shared coeffaddress with one registered 36-bit coefficient per filter.
//  - Host loads a new coefficient set into a shadow bank through a valid/ready stream.
//  - The shadow bank becomes active only on a sample boundary, so one MAC sweep never mixes old and new coefficients.
// PARAMETERS
//  NTAPS   64  taps per filter; words per filter in a load
//  AWIDTH  6   coeffaddress width; 2**AWIDTH >= NTAPS
//  CWIDTH  36  coefficient width (signed)
// PORTS
//  clock          in   1       master 250 MHz clock, rising edge
//  reset          in   1       synchronous, active high
//  din_enable     in   1       sample strobe (same signal profir sees); marks a sample boundary
//  coeffaddress   in   AWIDTH  tap address from profir
//  coeff0..coeff7 out  CWIDTH  each signed; active-bank coefficient of filter 0..7 at registered address
//  load_start     in   1       1-clock pulse: begin loading a full set into the shadow bank
//  load_valid     in   1       load_data is valid
//  load_data      in   CWIDTH  signed coefficient word
//  load_ready     out  1       block accepts load_data this cycle
//  load_done      out  1       1-clock pulse: new set is now active
// BEHAVIOUR
//  Reset values: coeff0..7=0, load_ready=0, load_done=0, active_sel=0, state=IDLE, counters=0.
//  - Memory contents are not cleared.
//  Storage: 2 banks x 8 filters x NTAPS words.
//  - active_sel selects the read bank; the write bank is always ~active_sel.
//  Read path: coeffN <= bank[active_sel][N][coeffaddress] every cycle, so latency is exactly 1 clock.
//  - coeffaddress >= NTAPS: all coeffN <= 0.
//  - Reads are never stalled, in any state.
//  FSM:
//  - IDLE: load_ready=0. load_start -> LOAD; clears tap_cnt and filt_cnt.
//  - LOAD: load_ready=1. A word transfers when load_valid & load_ready.
//    - Word goes to bank[~active_sel][filt_cnt][tap_cnt].
//    - tap_cnt counts 0..NTAPS-1. On wrap it returns to 0 and filt_cnt increments.
//    - Order: filter 0 taps 0..NTAPS-1, then filter 1, and so on (8*NTAPS words total).
//    - Transfer of the last word (filt_cnt=7, tap_cnt=NTAPS-1) -> PEND; load_ready drops the next cycle.
//    - load_start while in LOAD is ignored; no restart.
//  - PEND: load_ready=0.
//    - On din_enable=1: active_sel toggles, load_done=1 for that cycle, -> IDLE.
//    - A read issued in the same cycle as the toggle uses the old bank.
//    - The new bank is used from the next cycle.
//  - Simultaneous load_start and din_enable in PEND: the swap completes and load_start is dropped.
//  - load_valid while load_ready=0: word is discarded and no counter moves.
//  - Reset mid-LOAD or mid-PEND: the partial load is abandoned and active_sel returns to 0.
//    - Bank 0 holds whatever it held; the host must reload after reset.
//  Arithmetic: no arithmetic on data; words are stored bit-exact, sign preserved.
//  - Counter widths: tap_cnt is AWIDTH bits, filt_cnt is 3 bits.
// CONFIGURATION
//  CBS_IMMEDIATE_SWAP_EN
//  - Defined: PEND is skipped. The cycle after the last word transfers, active_sel toggles and load_done pulses, without waiting for din_enable.
//    - Used for bring-up with the filter idle.
//  - Undefined (default): swap occurs only on din_enable in PEND, as above.
// TESTING
//  1 Reset, then coeffaddress=5 -> all coeffN=0 at reset; after one clock out of reset coeffN = bank0 contents (X-free if preloaded).
//  2 Load 512 words, value = {filter,tap} (e.g. filter 3, tap 10 -> 36'h30A), with valid held high.
//    - load_ready=1 for 512 cycles.
//    - No swap until din_enable.
//    - On din_enable: load_done pulses once.
//    - Next cycle coeffaddress=10 -> coeff3=36'h30A one clock later.
//  3 During a load, sweep coeffaddress 0..63 -> coeffN match the old set every cycle.
//    - Insert din_enable mid-LOAD -> no swap.
//  4 Random gaps on load_valid plus load_start pulses mid-load.
//    - Word count still 512 -> correct placement, single load_done.
//  5 coeffaddress=63 then 6'h3F with NTAPS=48 -> outputs 0.
//    - load_data=36'h8_0000_0000 is read back unchanged (sign kept).
//  6 Assert reset at word 200 of a load.
//    - load_ready=0 and active_sel=0 next cycle, no load_done.
//    - A full reload then succeeds.
//    - With CBS_IMMEDIATE_SWAP_EN: load_done one cycle after the last word, no din_enable needed.

Source files
------------

// File: rtl/coeff_bank_server.sv
// Double-banked coefficient store for the 8-channel profir filter bank.
// Define CBS_IMMEDIATE_SWAP_EN to swap banks right after the last word instead of waiting for din_enable.
//
// state | meaning
// IDLE  | no load in progress, waiting for load_start
// LOAD  | accepting words into the shadow bank, filter-major order
// PEND  | shadow bank full, waiting for a sample boundary to swap
module coeff_bank_server #(
  parameter int NTAPS  = 64,
  parameter int AWIDTH = 6,
  parameter int CWIDTH = 36
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     din_enable,
  input  logic [AWIDTH-1:0]        coeffaddress,
  output logic signed [CWIDTH-1:0] coeff0,
  output logic signed [CWIDTH-1:0] coeff1,
  output logic signed [CWIDTH-1:0] coeff2,
  output logic signed [CWIDTH-1:0] coeff3,
  output logic signed [CWIDTH-1:0] coeff4,
  output logic signed [CWIDTH-1:0] coeff5,
  output logic signed [CWIDTH-1:0] coeff6,
  output logic signed [CWIDTH-1:0] coeff7,
  input  logic                     load_start,
  input  logic                     load_valid,
  input  logic signed [CWIDTH-1:0] load_data,
  output logic                     load_ready,
  output logic                     load_done
);

  typedef enum logic [1:0] {IDLE, LOAD, PEND} state_t;

  localparam logic [AWIDTH-1:0] LAST_TAP = AWIDTH'(NTAPS - 1);
  localparam logic [AWIDTH:0]   NTAPS_W  = (AWIDTH + 1)'(NTAPS);

  state_t              state, state_next;
  logic                active_sel;
  logic [AWIDTH-1:0]   tap_cnt;
  logic [2:0]          filt_cnt;
  logic                xfer;
  logic                last_word;
  logic                swap_go;
  logic [CWIDTH-1:0]   bank [2][8][NTAPS];
  logic [CWIDTH-1:0]   rd_q [8];

`ifdef CBS_IMMEDIATE_SWAP_EN
  assign swap_go = 1'b1;
`else
  assign swap_go = din_enable;
`endif

  assign last_word = (filt_cnt == 3'd7) && (tap_cnt == LAST_TAP);

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // load_done is gated by reset so a swap can never be reported that reset suppressed
  always_comb begin
    state_next = state;
    load_ready = 1'b0;
    load_done  = 1'b0;
    xfer       = 1'b0;
    case (state)
      IDLE: begin
        if (load_start) state_next = LOAD;
      end
      LOAD: begin
        load_ready = 1'b1;
        xfer       = load_valid;
        if (load_valid && last_word) state_next = PEND;
      end
      PEND: begin
        if (swap_go) begin
          load_done  = ~reset;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      active_sel <= 1'b0;
      tap_cnt    <= '0;
      filt_cnt   <= '0;
    end else begin
      if (state == IDLE && load_start) begin
        tap_cnt  <= '0;
        filt_cnt <= '0;
      end else if (xfer) begin
        if (tap_cnt == LAST_TAP) begin
          tap_cnt  <= '0;
          filt_cnt <= filt_cnt + 3'd1;
        end else begin
          tap_cnt <= tap_cnt + AWIDTH'(1);
        end
      end
      if (load_done) active_sel <= ~active_sel;
    end
  end

  // Storage is never cleared; writes always target the inactive bank
  always_ff @(posedge clock) begin
    if (xfer && !reset) bank[~active_sel][filt_cnt][tap_cnt] <= load_data;
  end

  always_ff @(posedge clock) begin
    for (int n = 0; n < 8; n++) begin
      if (reset || ({1'b0, coeffaddress} >= NTAPS_W)) begin
        rd_q[n] <= '0;
      end else begin
        rd_q[n] <= bank[active_sel][n][coeffaddress];
      end
    end
  end

  assign coeff0 = rd_q[0];
  assign coeff1 = rd_q[1];
  assign coeff2 = rd_q[2];
  assign coeff3 = rd_q[3];
  assign coeff4 = rd_q[4];
  assign coeff5 = rd_q[5];
  assign coeff6 = rd_q[6];
  assign coeff7 = rd_q[7];

endmodule

// File: tb/tb_coeff_bank_server.sv
// Randomised scoreboard bench for coeff_bank_server against a word-count reference model.
// Honours CBS_IMMEDIATE_SWAP_EN the same way the design does.
module tb_coeff_bank_server;

  localparam int NTAPS  = 64;
  localparam int AWIDTH = 6;
  localparam int CWIDTH = 36;
  localparam int NW     = 8 * NTAPS;

`ifdef CBS_IMMEDIATE_SWAP_EN
  localparam bit SWAP_IMM = 1'b1;
`else
  localparam bit SWAP_IMM = 1'b0;
`endif

  logic              clock = 1'b0;
  logic              reset, din_enable, load_start, load_valid;
  logic [AWIDTH-1:0] coeffaddress;
  logic [CWIDTH-1:0] load_data;
  logic              load_ready, load_done;
  logic [CWIDTH-1:0] c0, c1, c2, c3, c4, c5, c6, c7;

  coeff_bank_server #(.NTAPS(NTAPS), .AWIDTH(AWIDTH), .CWIDTH(CWIDTH)) dut (
    .clock(clock), .reset(reset), .din_enable(din_enable), .coeffaddress(coeffaddress),
    .coeff0(c0), .coeff1(c1), .coeff2(c2), .coeff3(c3),
    .coeff4(c4), .coeff5(c5), .coeff6(c6), .coeff7(c7),
    .load_start(load_start), .load_valid(load_valid), .load_data(load_data),
    .load_ready(load_ready), .load_done(load_done)
  );

  always #2 clock = ~clock;

  typedef struct packed {
    logic                   chk_ctl;
    logic                   ready;
    logic                   done;
    logic [7:0]             known;
    logic [7:0][CWIDTH-1:0] val;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;

  // Reference model: a set of 512 words per load, counted in arrival order
  logic [CWIDTH-1:0] m_mem   [2][8][NTAPS];
  bit                m_known [2][8][NTAPS];
  bit                m_act = 1'b0, m_loading = 1'b0, m_init = 1'b0;
  int                m_acc = 0;
  logic [CWIDTH-1:0] pr_val  [8];
  bit                pr_known[8];
  int                done_seen = 0;
  logic [AWIDTH-1:0] sweep_addr = '0;

  function automatic void check(input string name, input logic [CWIDTH-1:0] act,
                                input logic [CWIDTH-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endfunction

  always @(negedge clock) begin
    exp_t e;
    logic [CWIDTH-1:0] act [8];
    if (sb.size() > 0) begin
      e = sb.pop_front();
      act[0] = c0; act[1] = c1; act[2] = c2; act[3] = c3;
      act[4] = c4; act[5] = c5; act[6] = c6; act[7] = c7;
      if (e.chk_ctl) begin
        check("load_ready", CWIDTH'(load_ready), CWIDTH'(e.ready));
        check("load_done", CWIDTH'(load_done), CWIDTH'(e.done));
      end
      for (int n = 0; n < 8; n++)
        if (e.known[n]) check($sformatf("coeff%0d", n), act[n], e.val[n]);
    end
  end

  task automatic step(input bit rst, input bit st, input bit vl, input logic [CWIDTH-1:0] d,
                      input bit de, input logic [AWIDTH-1:0] a);
    exp_t e;
    bit rdy, swap;
    int f, t;
    reset = rst; load_start = st; load_valid = vl; load_data = d;
    din_enable = de; coeffaddress = a;
    rdy  = m_loading && (m_acc < NW);
    swap = m_loading && (m_acc == NW) && (SWAP_IMM || de);
    e.chk_ctl = m_init;
    e.ready   = rdy;
    e.done    = swap && !rst;
    if (e.done) done_seen++;
    for (int n = 0; n < 8; n++) begin
      e.known[n] = pr_known[n];
      e.val[n]   = pr_val[n];
    end
    sb.push_back(e);
    for (int n = 0; n < 8; n++) begin
      if (rst || int'(a) >= NTAPS) begin
        pr_val[n] = '0; pr_known[n] = 1'b1;
      end else begin
        pr_val[n] = m_mem[m_act][n][a]; pr_known[n] = m_known[m_act][n][a];
      end
    end
    if (rst) begin
      m_loading = 1'b0; m_acc = 0; m_act = 1'b0; m_init = 1'b1;
    end else if (rdy && vl) begin
      f = m_acc / NTAPS; t = m_acc % NTAPS;
      m_mem[!m_act][f][t] = d; m_known[!m_act][f][t] = 1'b1;
      m_acc++;
    end else if (swap) begin
      m_act = !m_act; m_loading = 1'b0;
    end else if (!m_loading && st) begin
      m_loading = 1'b1; m_acc = 0;
    end
    @(posedge clock); #1;
  endtask

  function automatic logic [CWIDTH-1:0] rand_word();
    logic [63:0] r;
    r = {$urandom, $urandom};
    return r[CWIDTH-1:0];
  endfunction

  function automatic logic [AWIDTH-1:0] next_addr(input bit sweep);
    if (sweep) begin
      sweep_addr = sweep_addr + AWIDTH'(1);
      return sweep_addr;
    end
    return AWIDTH'($urandom_range(0, (1 << AWIDTH) - 1));
  endfunction

  // mode 0: {filter,tap} pattern, 1: random, 2: random with sign-extreme words
  task automatic do_load(input int mode, input int vpct, input bit extra, input bit sweep,
                         input int abort_at);
    int cyc = 0;
    logic [CWIDTH-1:0] d;
    bit vl, st, de;
    step(0, 1, 0, '0, 0, next_addr(sweep));
    while (m_loading && m_acc < NW && cyc < 4000) begin
      if (abort_at >= 0 && m_acc == abort_at) break;
      case (mode)
        0:       d = CWIDTH'((m_acc / NTAPS) * 256 + (m_acc % NTAPS));
        2:       d = (m_acc % 37 == 0) ? 36'h8_0000_0000 : rand_word();
        default: d = rand_word();
      endcase
      vl = ($urandom_range(0, 99) < vpct);
      st = extra && ($urandom_range(0, 49) == 0);
      de = extra && ($urandom_range(0, 29) == 0);
      step(0, st, vl, d, de, next_addr(sweep));
      cyc++;
    end
    if (abort_at < 0 && m_acc != NW) begin
      vectors++; miscompares++;
      $display("FAIL load_progress: got %0d words expected %0d", m_acc, NW);
    end
  endtask

  task automatic idle(input int n, input bit sweep);
    for (int i = 0; i < n; i++)
      step(0, 0, 1'($urandom_range(0, 1)), rand_word(), 0, next_addr(sweep));
  endtask

  task automatic swap_now(input bit with_start);
    step(0, with_start, 0, '0, 1, next_addr(0));
  endtask

  initial begin
    int guard;
    int done_before;
    for (int n = 0; n < 8; n++) begin
      pr_val[n] = '0; pr_known[n] = 1'b0;
    end
    for (int b = 0; b < 2; b++)
      for (int f = 0; f < 8; f++)
        for (int t = 0; t < NTAPS; t++) m_known[b][f][t] = 1'b0;
    reset = 1'b1; din_enable = 1'b0; load_start = 1'b0; load_valid = 1'b0;
    load_data = '0; coeffaddress = 6'd5;
    @(posedge clock); #1;

    repeat (3) step(1, 0, 0, '0, 0, 6'd5);
    repeat (2) step(0, 0, 0, '0, 0, 6'd5);

    do_load(0, 100, 0, 0, -1);
    idle(5, 0);
    swap_now(1);
    repeat (3) step(0, 0, 0, '0, 0, 6'd10);
    idle(4, 0);

    do_load(1, 60, 1, 1, -1);
    idle(3, 0);
    swap_now(0);
    idle(70, 1);

    do_load(2, 80, 1, 1, -1);
    idle(2, 0);
    swap_now(0);
    idle(70, 1);

    done_before = done_seen;
    do_load(1, 100, 0, 0, 200);
    step(1, 0, 1, rand_word(), 1, next_addr(0));
    idle(5, 0);
    vectors++;
    if (done_seen != done_before) begin
      miscompares++;
      $display("FAIL abort_done_count: got %0d expected %0d", done_seen, done_before);
    end

    do_load(0, 75, 1, 1, -1);
    idle(3, 0);
    swap_now(0);
    idle(70, 1);

    guard = 0;
    while (sb.size() > 0 && guard < 50) begin
      @(posedge clock); #1;
      guard++;
    end
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end
    vectors++;
    if (done_seen != 4) begin
      miscompares++;
      $display("FAIL swap_count: got %0d expected 4", done_seen);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
